ahb_lite_slave: RTL and testbench
=================================

Name: ahb_lite_slave

Overview:
- AHB-Lite responder (slave) backed by a word-addressed register/memory array.
- It is the target end of the bus for the team's AHB-Lite master: it accepts single and burst transfers, inserts programmable wait states, and signals errors.
- It is the memory-side end point that later feeds the AHB-to-SPI bridge data path.

Parameters:
- DEPTH, 64, number of 32-bit words; the byte address space is DEPTH*4 and must be at most 256.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted in every OKAY data phase; legal range 0..7.
- ADDR_LIMIT, 8'hFF, highest legal byte address; any byte of a transfer above it gives an ERROR response.

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  reset
- HSEL  in  1  slave select from decoder
- HADDR  in  8  byte address
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1 = write
- HSIZE  in  3  000 = byte, 001 = halfword, 010 = word
- HBURST  in  3  burst type; accepted and not used (the address is taken from HADDR on every beat)
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  global bus ready (the mux of all HREADYOUTs)
- HRDATA  out  32  read data
- HREADYOUT  out  1  this slave's ready
- HRESP  out  1  0 = OKAY, 1 = ERROR

Interface decision: reset HRESETn, asynchronous, active-low; clock HCLK.

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM in IDLE, wait counter 0, every memory word 0.
- Reset is asynchronous and may arrive at any cycle, including mid data phase. It aborts the transfer; a pending write is not committed.
- Address-phase accept: sample on a rising HCLK when HSEL & HTRANS[1] & HREADY.
- On accept, register addr, write, size, and err.
- err is set for any of:
  - HSIZE > 010;
  - misalignment: halfword with HADDR[0]=1, or word with HADDR[1:0]!=0;
  - last byte address > ADDR_LIMIT or >= DEPTH*4.
- IDLE/BUSY transfers, or HSEL=0, are not accepted. The next cycle is a zero-wait OKAY: HREADYOUT=1, HRESP=0.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - Accept & err -> ERR1.
  - Accept & !err & WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
  - Accept & !err & WAIT_STATES==0 -> DATA.
  - No accept -> IDLE.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements; go to DATA after the cycle where the counter is 0. This gives exactly WAIT_STATES low cycles.
  - DATA: HREADYOUT=1, HRESP=0; the transfer completes at the end of this cycle. A new address phase may be accepted in the same cycle (pipelined). Next state follows the accept rules above.
  - ERR1: HREADYOUT=0, HRESP=1. Always -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A new address phase may be accepted; next state follows the accept rules.
- Write commit:
  - Happens at the rising edge ending DATA.
  - Byte lane enables follow size/addr, little-endian: byte uses lane addr[1:0]; halfword uses lanes {addr[1],0} and {addr[1],1}; word uses all four lanes.
  - Only enabled lanes are updated from the matching HWDATA bytes.
  - Errored transfers never write.
- Read data:
  - HRDATA = mem[addr[7:2]] (full word, all lanes), combinational, during DATA of a read.
  - HRDATA = 0 in every other state.
  - Read-after-write works with no hazard: with 0 wait states, the write commits at the edge that starts the next read's DATA.
- Back-to-back accepts with WAIT_STATES=0 give a sustained one beat per cycle (INCR4 completes in 4 consecutive DATA cycles).
- HBURST and SEQ/NONSEQ are handled identically. An early-terminated burst (master issues IDLE) needs no special handling.
- After an ERROR the master normally drives IDLE in ERR2. A non-IDLE transfer in ERR2 is still accepted.

Decomposition:
- Package ahb_lite_pkg holds:
  - HTRANS codes: IDLE, BUSY, NONSEQ, SEQ;
  - HSIZE codes: BYTE, HALF, WORD;
  - HRESP codes: OKAY, ERROR;
  - FSM state encoding.
- Sub-module ahb_slave_mem: DEPTH x 32 array with async clear, 4-bit byte write-enable, combinational read port.
- Lane-enable and error decode stay in ahb_lite_slave.

Test Plan:
- Reset then idle -> HREADYOUT=1, HRESP=0, HRDATA=0; a read of 0x10 returns 0x00000000.
- INCR4 word write at 0x10 of 0x11111111, 0x22222222, 0x33333333, 0x44444444 with WAIT_STATES=0, then INCR4 read at 0x10 -> 4 consecutive DATA cycles each way; reads return the same words in order.
- Byte write 0xAB to 0x21, then halfword write 0xCDEF to 0x22, then word read 0x20 -> 0xCDEFAB00.
- WAIT_STATES=3: single word read of 0x14 -> exactly 3 cycles of HREADYOUT=0, then data on the 4th data-phase cycle.
- Word write to 0x12 (misaligned), and HSIZE=011 -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (1,1); the memory word is unchanged.
- Assert HRESETn low in the middle of a WAIT on a write to 0x30 -> outputs return to reset values immediately; word 0x30 reads back 0.

Source files
------------

// File: rtl/ahb_lite_slave_pkg.sv
// Shared AHB-Lite encodings and FSM state for the memory-backed responder.
package ahb_lite_pkg;

   typedef enum logic [1:0] {
      TR_IDLE   = 2'b00,
      TR_BUSY   = 2'b01,
      TR_NONSEQ = 2'b10,
      TR_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      SZ_BYTE = 3'b000,
      SZ_HALF = 3'b001,
      SZ_WORD = 3'b010
   } hsize_e;

   typedef enum logic {
      RESP_OKAY  = 1'b0,
      RESP_ERROR = 1'b1
   } hresp_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_e;

   localparam int NUM_LANES = 4;

   // Byte offset of the last byte touched by a transfer of a legal size.
   function automatic logic [8:0] size_span(input logic [1:0] sz);
      return (9'd1 << sz) - 9'd1;
   endfunction

endpackage

// File: rtl/ahb_lite_slave_if.sv
// AHB-Lite bus bundle between one master and one responder.
interface ahb_lite_slave_if;
   logic        HSEL;
   logic [7:0]  HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
      output HRDATA, HREADYOUT, HRESP
   );

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
      input  HREADY, HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/ahb_slave_mem.sv
// Word array split into independent byte lanes; per-lane write enable, async clear.
module ahb_slave_mem
   import ahb_lite_pkg::*;
#(
   parameter int DEPTH = 64,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                           HCLK,
   input  logic                           HRESETn,
   input  logic [AW-1:0]                  idx,
   input  logic [NUM_LANES-1:0]           we,
   input  logic [NUM_LANES-1:0][7:0]      wdata,
   output logic [NUM_LANES-1:0][7:0]      rdata
);

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic [7:0] lane_q [DEPTH];

      // Lane storage: cleared on reset, updated only when this lane is enabled.
      always_ff @(posedge HCLK or negedge HRESETn) begin
         if (!HRESETn) begin
            for (int i = 0; i < DEPTH; i++) lane_q[i] <= '0;
         end else if (we[l]) begin
            lane_q[idx] <= wdata[l];
         end
      end

      assign rdata[l] = lane_q[idx];
   end

endmodule

// File: rtl/ahb_lite_slave.sv
// AHB-Lite responder: address-phase decode, wait/error FSM, byte-lane writes.
module ahb_lite_slave
   import ahb_lite_pkg::*;
#(
   parameter int         DEPTH       = 64,
   parameter int         WAIT_STATES = 0,
   parameter logic [7:0] ADDR_LIMIT  = 8'hFF
) (
   input logic              HCLK,
   input logic              HRESETn,
   ahb_lite_slave_if.slave  bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_e                  state_q, state_d;
   logic [2:0]              cnt_q, cnt_d;
   logic [7:0]              addr_q;
   logic                    write_q, err_q;
   logic [1:0]              size_q;
   logic                    addr_ok_st, accept, err;
   logic                    size_bad, misalign;
   logic [8:0]              last_byte;
   logic [NUM_LANES-1:0]    be, we;
   logic [31:0]             rdata;
   logic                    ready;
   hresp_e                  resp;
   logic                    unused_bits;

   assign unused_bits = ^{bus.HBURST, bus.HTRANS[0]};

   // HREADY is low in WAIT/ERR1 on a well-formed bus; the state gate keeps a
   // stray accept from overwriting the captured address mid data phase.
   assign addr_ok_st = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
   assign accept     = addr_ok_st & bus.HSEL & bus.HTRANS[1] & bus.HREADY;

   // Error decode of the address phase: bad size, misalignment, out of range.
   always_comb begin
      size_bad  = bus.HSIZE > SZ_WORD;
      misalign  = ((bus.HSIZE == SZ_HALF) && bus.HADDR[0]) ||
                  ((bus.HSIZE == SZ_WORD) && (bus.HADDR[1:0] != 2'b00));
      last_byte = {1'b0, bus.HADDR} + size_span(bus.HSIZE[1:0]);
      err       = size_bad || misalign ||
                  (last_byte > {1'b0, ADDR_LIMIT}) || (last_byte >= 9'(DEPTH * 4));
   end

   // Little-endian lane enables from the captured size and address.
   always_comb begin
      case (size_q)
         2'd0:    be = 4'b0001 << addr_q[1:0];
         2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   // Capture the address phase on accept.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         addr_q  <= bus.HADDR;
         write_q <= bus.HWRITE;
         size_q  <= bus.HSIZE[1:0];
         err_q   <= err;
      end
   end

   // State and wait-counter registers.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and data-phase response.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready   = 1'b1;
      resp    = RESP_OKAY;
      case (state_q)
         ST_WAIT: begin
            ready = 1'b0;
            if (cnt_q == 3'd0) state_d = ST_DATA;
            else               cnt_d   = cnt_q - 3'd1;
         end
         ST_ERR1: begin
            ready   = 1'b0;
            resp    = RESP_ERROR;
            state_d = ST_ERR2;
         end
         default: begin
            resp = (state_q == ST_ERR2) ? RESP_ERROR : RESP_OKAY;
            if (!accept) begin
               state_d = ST_IDLE;
            end else if (err) begin
               state_d = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
               state_d = ST_WAIT;
               cnt_d   = 3'(WAIT_STATES - 1);
            end else begin
               state_d = ST_DATA;
            end
         end
      endcase
   end

   assign we = (state_q == ST_DATA && write_q && !err_q) ? be : '0;

   ahb_slave_mem #(.DEPTH(DEPTH)) u_mem (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .idx     (addr_q[AW+1:2]),
      .we      (we),
      .wdata   (bus.HWDATA),
      .rdata   (rdata)
   );

   assign bus.HRDATA    = (state_q == ST_DATA && !write_q) ? rdata : 32'h0;
   assign bus.HREADYOUT = ready;
   assign bus.HRESP     = resp;

endmodule

// File: tb/tb_ahb_lite_slave.sv
// Randomised scoreboard bench: two responders (0 and 3 wait states) behind one master model.
module tb_ahb_lite_slave;
   import ahb_lite_pkg::*;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          waits;
      logic [7:0]  addr;
   } exp_t;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   always #5 HCLK = ~HCLK;

   ahb_lite_slave_if if0 ();
   ahb_lite_slave_if if3 ();

   logic        cur = 1'b0;
   logic        hsel = 1'b0;
   logic [7:0]  haddr = '0;
   logic [1:0]  htrans = TR_IDLE;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = SZ_WORD;
   logic [2:0]  hburst = '0;
   logic [31:0] hwdata = '0;

   assign if0.HSEL = hsel & ~cur;   assign if3.HSEL = hsel & cur;
   assign if0.HADDR = haddr;        assign if3.HADDR = haddr;
   assign if0.HTRANS = htrans;      assign if3.HTRANS = htrans;
   assign if0.HWRITE = hwrite;      assign if3.HWRITE = hwrite;
   assign if0.HSIZE = hsize;        assign if3.HSIZE = hsize;
   assign if0.HBURST = hburst;      assign if3.HBURST = hburst;
   assign if0.HWDATA = hwdata;      assign if3.HWDATA = hwdata;
   assign if0.HREADY = if0.HREADYOUT;
   assign if3.HREADY = if3.HREADYOUT;

   logic        ready_m, resp_m;
   logic [31:0] rdata_m;
   assign ready_m = cur ? if3.HREADYOUT : if0.HREADYOUT;
   assign resp_m  = cur ? if3.HRESP     : if0.HRESP;
   assign rdata_m = cur ? if3.HRDATA    : if0.HRDATA;

   ahb_lite_slave #(.DEPTH(64), .WAIT_STATES(0), .ADDR_LIMIT(8'hEF)) dut0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .bus(if0));
   ahb_lite_slave #(.DEPTH(32), .WAIT_STATES(3), .ADDR_LIMIT(8'hFF)) dut3 (
      .HCLK(HCLK), .HRESETn(HRESETn), .bus(if3));

   int          errors = 0;
   int          checks = 0;
   exp_t        q[$];
   bit          busy = 0;
   time         acc_t;
   logic [7:0]  refm [2][256];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Highest legal last-byte address of each responder (range limit vs. array size).
   function automatic int last_ok(input logic d);
      return d ? 127 : 'hEF;
   endfunction

   function automatic void ref_clear();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 256; i++) refm[d][i] = '0;
   endfunction

   // One beat: hold the address phase until accepted, predict the response, then
   // present its write data for the data phase.
   task automatic beat(input logic [7:0] a, input logic wr, input logic [2:0] sz,
                       input logic [31:0] d, input logic [1:0] tr = TR_NONSEQ);
      exp_t e;
      int   n, t;
      bit   bad;
      hsel = 1'b1; haddr = a; htrans = tr; hwrite = wr; hsize = sz;
      hburst = 3'($urandom_range(0, 7));
      t = 0;
      forever begin
         @(negedge HCLK);
         if (ready_m) break;
         t++;
         if (t > 50) begin
            check("accept_timeout", 32'(t), 32'd0);
            return;
         end
      end
      @(posedge HCLK);
      n   = (sz <= 3'd2) ? (1 << sz) : 1;
      bad = (sz > 3'd2) || ((int'(a) % n) != 0) || (int'(a) + n - 1 > last_ok(cur));
      e.err   = bad;
      e.waits = bad ? 1 : (cur ? 3 : 0);
      e.addr  = a;
      e.rdata = '0;
      if (!bad && wr)
         for (int i = 0; i < n; i++) refm[cur][int'(a) + i] = d[8 * ((int'(a) + i) % 4) +: 8];
      if (!bad && !wr)
         for (int i = 0; i < 4; i++) e.rdata[8 * i +: 8] = refm[cur][int'({a[7:2], 2'b00}) + i];
      q.push_back(e);
      acc_t = $time;
      #1 hwdata = d;
   endtask

   task automatic drain();
      hsel = 1'b0; htrans = TR_IDLE;
      for (int t = 0; t < 100; t++) begin
         @(posedge HCLK);
         if (!busy && q.size() == 0) begin
            #1;
            return;
         end
      end
      check("drain_timeout", 32'(q.size()), 32'd0);
   endtask

   // Monitor: pop the expected response when a data phase starts and compare it
   // when the responder raises HREADYOUT; idle cycles must look like zero-wait OKAY.
   initial begin : monitor
      exp_t c;
      int   low;
      bit   lowbad;
      forever begin
         @(negedge HCLK);
         if (!HRESETn) begin
            busy = 0;
            q.delete();
            continue;
         end
         if (!busy && q.size() > 0) begin
            c = q.pop_front(); busy = 1; low = 0; lowbad = 0;
         end
         if (busy) begin
            if (!ready_m) begin
               low++;
               if (resp_m !== c.err || rdata_m !== 32'h0) lowbad = 1;
            end else begin
               check($sformatf("waits@%h", c.addr), 32'(low), 32'(c.waits));
               check($sformatf("lowphase@%h", c.addr), {31'b0, lowbad}, 32'd0);
               check($sformatf("resp@%h", c.addr), {31'b0, resp_m}, {31'b0, c.err});
               check($sformatf("rdata@%h", c.addr), rdata_m, c.rdata);
               busy = 0;
            end
         end else begin
            check("idle_ready", {31'b0, ready_m}, 32'd1);
            check("idle_resp", {31'b0, resp_m}, 32'd0);
            check("idle_rdata", rdata_m, 32'h0);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      time t1;
      logic [7:0] a;
      logic [2:0] sz;
      ref_clear();
      #3;
      check("rst_ready0", {31'b0, if0.HREADYOUT}, 32'd1);
      check("rst_resp3", {31'b0, if3.HRESP}, 32'd0);
      check("rst_rdata3", if3.HRDATA, 32'h0);
      #19 HRESETn = 1'b1;
      drain();

      // Reset memory reads zero.
      cur = 1'b0;
      beat(8'h10, 1'b0, SZ_WORD, '0);
      drain();

      // INCR4 write then INCR4 read, back to back, one beat per cycle.
      beat(8'h10, 1'b1, SZ_WORD, 32'h11111111, TR_NONSEQ); t1 = acc_t;
      beat(8'h14, 1'b1, SZ_WORD, 32'h22222222, TR_SEQ);
      beat(8'h18, 1'b1, SZ_WORD, 32'h33333333, TR_SEQ);
      beat(8'h1C, 1'b1, SZ_WORD, 32'h44444444, TR_SEQ);
      check("incr4_wr_span", 32'(acc_t - t1), 32'd30);
      beat(8'h10, 1'b0, SZ_WORD, '0, TR_NONSEQ); t1 = acc_t;
      beat(8'h14, 1'b0, SZ_WORD, '0, TR_SEQ);
      beat(8'h18, 1'b0, SZ_WORD, '0, TR_SEQ);
      beat(8'h1C, 1'b0, SZ_WORD, '0, TR_SEQ);
      check("incr4_rd_span", 32'(acc_t - t1), 32'd30);
      drain();

      // Sub-word lanes: expected word 0xCDEFAB00.
      beat(8'h21, 1'b1, SZ_BYTE, 32'h0000AB00);
      beat(8'h22, 1'b1, SZ_HALF, 32'hCDEF0000);
      beat(8'h20, 1'b0, SZ_WORD, '0);
      drain();

      // Error responses leave memory untouched.
      beat(8'h12, 1'b1, SZ_WORD, 32'hBAD0BAD0);
      drain();
      beat(8'h10, 1'b1, 3'b011, 32'hBAD1BAD1);
      drain();
      beat(8'h10, 1'b0, SZ_WORD, '0);
      beat(8'h10, 1'b0, SZ_WORD, '0);
      // Range edge of the 0xEF limit.
      beat(8'hEC, 1'b1, SZ_WORD, 32'h5A5A5A5A);
      beat(8'hF0, 1'b1, SZ_WORD, 32'hA5A5A5A5);
      beat(8'hEF, 1'b0, SZ_BYTE, '0);
      beat(8'hF0, 1'b0, SZ_BYTE, '0);
      drain();

      // Three wait states; range edge of the 32-word array.
      cur = 1'b1;
      beat(8'h14, 1'b1, SZ_WORD, $urandom());
      beat(8'h14, 1'b0, SZ_WORD, '0);
      beat(8'h7C, 1'b1, SZ_WORD, 32'h0BADF00D);
      beat(8'h7E, 1'b0, SZ_HALF, '0);
      beat(8'h80, 1'b0, SZ_BYTE, '0);
      drain();

      // Random traffic on both responders.
      for (int blk = 0; blk < 8; blk++) begin
         cur = blk[0];
         for (int k = 0; k < 25; k++) begin
            a  = 8'($urandom_range(0, 255));
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) a = a & ~((8'd1 << sz[1:0]) - 8'd1);
            if ($urandom_range(0, 3) == 0) a = a & 8'h3F;
            beat(a, 1'($urandom_range(0, 1)), sz, $urandom(), 2'($urandom_range(2, 3)));
            if ($urandom_range(0, 3) == 0) begin
               hsel = 1'($urandom_range(0, 1)); htrans = 2'($urandom_range(0, 1));
               @(posedge HCLK); #1;
            end
         end
         drain();
      end

      // Reset in the middle of a waited write: nothing commits.
      cur = 1'b1;
      beat(8'h30, 1'b1, SZ_WORD, 32'hDEADBEEF);
      hsel = 1'b0; htrans = TR_IDLE;
      @(negedge HCLK);
      #2 HRESETn = 1'b0;
      #1;
      check("midrst_ready", {31'b0, if3.HREADYOUT}, 32'd1);
      check("midrst_resp", {31'b0, if3.HRESP}, 32'd0);
      check("midrst_rdata", if3.HRDATA, 32'h0);
      ref_clear();
      @(posedge HCLK);
      @(posedge HCLK);
      #2 HRESETn = 1'b1;
      drain();
      beat(8'h30, 1'b0, SZ_WORD, '0);
      drain();
      cur = 1'b0;
      beat(8'h10, 1'b0, SZ_WORD, '0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
